// File: rtl/ip_fifo_wr_arb_if.sv
// Requester / FIFO write-side bundle for ip_fifo_wr_arb.
// The arbiter takes the slave view; requesters and the FIFO model take the master view.
interface ip_fifo_wr_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_din;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/ip_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Grants are packet-locked: a requester keeps the port until its last beat is written.
module ip_fifo_wr_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    ip_fifo_wr_arb_if.slave arb
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] scan_cand;
    logic [IDW-1:0] scan_idx;
    logic           scan_found;
    logic [IDW-1:0] cand;
    logic           accept;

    // Explicit compare keeps the wrap correct when NREQ is not a power of two.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
        logic [IDW-1:0] r;
        if (x == IDW'(NREQ - 1)) begin
            r = '0;
        end else begin
            r = x + 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        scan_cand  = '0;
        scan_found = 1'b0;
        scan_idx   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!scan_found && arb.req_valid[scan_idx]) begin
                scan_cand  = scan_idx;
                scan_found = 1'b1;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    assign cand   = (state == LOCKED) ? owner : scan_cand;
    assign accept = arb.req_valid[cand] && !arb.fifo_full && rst;

    always_comb begin
        arb.req_ready       = '0;
        arb.req_ready[cand] = accept;
    end

    assign arb.fifo_wr_en = accept;
    assign arb.fifo_din   = arb.req_data[cand*WIDTH +: WIDTH];
    assign arb.grant_id   = rst ? cand : '0;
    assign arb.busy       = rst && (state == LOCKED);

    // Fairness is per packet: rr_ptr only moves when a last beat is written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (arb.req_last[cand]) begin
                        rr_ptr <= wrap_inc(cand);
                    end else begin
                        state <= LOCKED;
                        owner <= cand;
                    end
                end
                LOCKED: begin
                    if (arb.req_last[cand]) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(owner);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_fifo_wr_arb.sv
// Bench for ip_fifo_wr_arb: directed vector table (NREQ=4), hand sequence (NREQ=3),
// then randomized traffic on both instances against a packet-level reference model.
module tb_ip_fifo_wr_arb;

    logic clk;
    logic rst4;
    logic rst3;

    ip_fifo_wr_arb_if #(.WIDTH(8), .NREQ(4)) if4 ();
    ip_fifo_wr_arb_if #(.WIDTH(8), .NREQ(3)) if3 ();

    ip_fifo_wr_arb #(.WIDTH(8), .NREQ(4)) dut4 (.clk(clk), .rst(rst4), .arb(if4.slave));
    ip_fifo_wr_arb #(.WIDTH(8), .NREQ(3)) dut3 (.clk(clk), .rst(rst3), .arb(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rstn;
        logic        full;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        wr;
        logic [7:0]  din;
        logic [3:0]  rdy;
        logic [1:0]  gnt;
        logic        busy;
        logic        chk_din;
    } vec_t;

    vec_t tv[$];

    // Reference model state, index 0 = NREQ 4 instance, 1 = NREQ 3 instance.
    bit m_locked[2];
    int m_owner[2];
    int m_ptr[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic rstn, input logic full, input logic [3:0] valid,
                       input logic [3:0] last, input logic [31:0] data, input logic wr,
                       input logic [7:0] din, input logic [3:0] rdy, input logic [1:0] gnt,
                       input logic busy, input logic chk_din);
        vec_t v;
        v.rstn = rstn; v.full = full; v.valid = valid; v.last = last; v.data = data;
        v.wr = wr; v.din = din; v.rdy = rdy; v.gnt = gnt; v.busy = busy; v.chk_din = chk_din;
        tv.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_check(input int d, input int n, input string tag,
                               input logic rstn, input logic full,
                               input logic [3:0] valid, input logic [3:0] last,
                               input logic [31:0] data, input logic act_wr,
                               input logic [7:0] act_din, input logic [3:0] act_rdy,
                               input logic [1:0] act_gnt, input logic act_busy);
        int  cand;
        bit  found;
        bit  acc;
        cand  = 0;
        found = 0;
        if (m_locked[d]) begin
            cand = m_owner[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                if (!found && valid[(m_ptr[d] + k) % n]) begin
                    cand  = (m_ptr[d] + k) % n;
                    found = 1;
                end
            end
        end
        acc = rstn && !full && valid[cand];
        chk({tag, ".wr"},   32'(act_wr),   32'(acc));
        chk({tag, ".rdy"},  32'(act_rdy),  acc ? (32'd1 << cand) : 32'd0);
        chk({tag, ".gnt"},  32'(act_gnt),  rstn ? 32'(cand) : 32'd0);
        chk({tag, ".busy"}, 32'(act_busy), 32'(rstn && m_locked[d]));
        if (rstn) chk({tag, ".din"}, 32'(act_din), 32'(data[cand*8 +: 8]));
        if (!rstn) begin
            m_locked[d] = 0;
            m_owner[d]  = 0;
            m_ptr[d]    = 0;
        end else if (acc) begin
            if (m_locked[d]) begin
                if (last[cand]) begin
                    m_locked[d] = 0;
                    m_ptr[d]    = (m_owner[d] + 1) % n;
                end
            end else if (last[cand]) begin
                m_ptr[d] = (cand + 1) % n;
            end else begin
                m_locked[d] = 1;
                m_owner[d]  = cand;
            end
        end
    endtask

    initial begin
        rst4 = 1'b0;
        rst3 = 1'b0;
        if4.req_valid = '0; if4.req_last = '0; if4.req_data = '0; if4.fifo_full = 1'b0;
        if3.req_valid = '0; if3.req_last = '0; if3.req_data = '0; if3.fifo_full = 1'b0;

        // Reset with everything valid, then 8 single-beat round-robin grants.
        for (int i = 0; i < 3; i++)
            add(0, 0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 8'h00, 4'h0, 2'd0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(1, 0, 4'hF, 4'hF, 32'hA3A2A1A0, 1, 8'(8'hA0 + i % 4),
                4'(1 << (i % 4)), 2'(i % 4), 0, 1);
        // Packet lock: req1 three beats while req2 waits.
        add(1, 0, 4'b0110, 4'b0000, 32'hA32211A0, 1, 8'h11, 4'b0010, 2'd1, 0, 1);
        add(1, 0, 4'b0110, 4'b0000, 32'hA32212A0, 1, 8'h12, 4'b0010, 2'd1, 1, 1);
        add(1, 0, 4'b0110, 4'b0010, 32'hA32213A0, 1, 8'h13, 4'b0010, 2'd1, 1, 1);
        add(1, 0, 4'b0100, 4'b0100, 32'hA32213A0, 1, 8'h22, 4'b0100, 2'd2, 0, 1);
        // Full stall in the middle of req0's 4-beat packet.
        add(1, 0, 4'b0001, 4'b0000, 32'h00000001, 1, 8'h01, 4'b0001, 2'd0, 0, 1);
        add(1, 0, 4'b0001, 4'b0000, 32'h00000002, 1, 8'h02, 4'b0001, 2'd0, 1, 1);
        for (int i = 0; i < 5; i++)
            add(1, 1, 4'b0001, 4'b0000, 32'h00000003, 0, 8'h03, 4'b0000, 2'd0, 1, 1);
        add(1, 0, 4'b0001, 4'b0000, 32'h00000003, 1, 8'h03, 4'b0001, 2'd0, 1, 1);
        add(1, 0, 4'b0001, 4'b0001, 32'h00000004, 1, 8'h04, 4'b0001, 2'd0, 1, 1);
        // Owner gap: req3 drops valid for two cycles while req0 waits.
        add(1, 0, 4'b1001, 4'b0000, 32'h3100000F, 1, 8'h31, 4'b1000, 2'd3, 0, 1);
        add(1, 0, 4'b0001, 4'b0000, 32'h3100000F, 0, 8'h31, 4'b0000, 2'd3, 1, 1);
        add(1, 0, 4'b0001, 4'b0000, 32'h3100000F, 0, 8'h31, 4'b0000, 2'd3, 1, 1);
        add(1, 0, 4'b1001, 4'b1000, 32'h3200000F, 1, 8'h32, 4'b1000, 2'd3, 1, 1);
        add(1, 0, 4'b0001, 4'b0001, 32'h3200000F, 1, 8'h0F, 4'b0001, 2'd0, 0, 1);

        foreach (tv[i]) begin
            rst4          = tv[i].rstn;
            if4.fifo_full = tv[i].full;
            if4.req_valid = tv[i].valid;
            if4.req_last  = tv[i].last;
            if4.req_data  = tv[i].data;
            @(negedge clk);
            chk($sformatf("tv%0d.wr", i),   32'(if4.fifo_wr_en), 32'(tv[i].wr));
            chk($sformatf("tv%0d.rdy", i),  32'(if4.req_ready),  32'(tv[i].rdy));
            chk($sformatf("tv%0d.gnt", i),  32'(if4.grant_id),   32'(tv[i].gnt));
            chk($sformatf("tv%0d.busy", i), 32'(if4.busy),       32'(tv[i].busy));
            if (tv[i].chk_din)
                chk($sformatf("tv%0d.din", i), 32'(if4.fifo_din), 32'(tv[i].din));
            tick();
        end

        // NREQ=3: wrap after req2, then reset in the middle of req1's packet.
        rst4 = 1'b0;
        rst3 = 1'b0;
        if3.req_valid = 3'b000;
        tick();
        rst3 = 1'b1;
        if3.req_valid = 3'b100; if3.req_last = 3'b000; if3.req_data = 24'h2A1C0C;
        @(negedge clk);
        chk("n3.p2b1.gnt", 32'(if3.grant_id), 32'd2);
        chk("n3.p2b1.din", 32'(if3.fifo_din), 32'h2A);
        tick();
        if3.req_last = 3'b100; if3.req_data = 24'h2B1C0C;
        @(negedge clk);
        chk("n3.p2b2.busy", 32'(if3.busy), 32'd1);
        chk("n3.p2b2.wr",   32'(if3.fifo_wr_en), 32'd1);
        tick();
        if3.req_valid = 3'b011; if3.req_last = 3'b011;
        @(negedge clk);
        chk("n3.wrap.gnt", 32'(if3.grant_id), 32'd0);
        chk("n3.wrap.rdy", 32'(if3.req_ready), 32'b001);
        tick();
        if3.req_valid = 3'b010; if3.req_last = 3'b000;
        @(negedge clk);
        chk("n3.p1b1.gnt", 32'(if3.grant_id), 32'd1);
        chk("n3.p1b1.rdy", 32'(if3.req_ready), 32'b010);
        tick();
        rst3 = 1'b0; if3.req_valid = 3'b111;
        @(negedge clk);
        chk("n3.rst.wr",   32'(if3.fifo_wr_en), 32'd0);
        chk("n3.rst.rdy",  32'(if3.req_ready),  32'd0);
        chk("n3.rst.busy", 32'(if3.busy),       32'd0);
        tick();
        rst3 = 1'b1;
        @(negedge clk);
        chk("n3.post.busy", 32'(if3.busy),       32'd0);
        chk("n3.post.gnt",  32'(if3.grant_id),   32'd0);
        chk("n3.post.rdy",  32'(if3.req_ready),  32'b001);
        tick();

        // Randomized traffic on both instances; the first cycle resets both.
        for (int c = 0; c < 3000; c++) begin
            rst4          = (c == 0) ? 1'b0 : (($urandom % 60) != 0);
            rst3          = (c == 0) ? 1'b0 : (($urandom % 60) != 0);
            if4.req_valid = 4'($urandom | $urandom);
            if4.req_last  = 4'($urandom & $urandom);
            if4.req_data  = $urandom;
            if4.fifo_full = (($urandom % 5) == 0);
            if3.req_valid = 3'($urandom | $urandom);
            if3.req_last  = 3'($urandom & $urandom);
            if3.req_data  = 24'($urandom);
            if3.fifo_full = (($urandom % 5) == 0);
            @(negedge clk);
            model_check(0, 4, $sformatf("r4c%0d", c), rst4, if4.fifo_full,
                        if4.req_valid, if4.req_last, if4.req_data, if4.fifo_wr_en,
                        if4.fifo_din, if4.req_ready, if4.grant_id, if4.busy);
            model_check(1, 3, $sformatf("r3c%0d", c), rst3, if3.fifo_full,
                        {1'b0, if3.req_valid}, {1'b0, if3.req_last}, {8'h00, if3.req_data},
                        if3.fifo_wr_en, if3.fifo_din, {1'b0, if3.req_ready},
                        if3.grant_id, if3.busy);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
